// File: rtl/light_pkg.sv
// Shared constants, mode encoding and default palette for the light sequencer.
package light_pkg;

  localparam int COLOUR_W = 24;
  localparam logic [COLOUR_W-1:0] WHITE = 24'hFFFFFF;
  localparam logic [COLOUR_W-1:0] BLACK = 24'h000000;

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'b00,
    MODE_EDGE   = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_e;

  // Entries past the six primaries/secondaries fall back to mid grey.
  function automatic logic [COLOUR_W-1:0] default_colour(input int entry);
    case (entry)
      1:       default_colour = 24'hFF0000;
      2:       default_colour = 24'h00FF00;
      3:       default_colour = 24'h0000FF;
      4:       default_colour = 24'hFFFF00;
      5:       default_colour = 24'h00FFFF;
      6:       default_colour = 24'hFF00FF;
      default: default_colour = 24'h808080;
    endcase
  endfunction

endpackage

// File: rtl/light_sequencer_if.sv
// Button/switch, palette-write and LED-colour signals of the light sequencer.
interface light_sequencer_if #(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 6,
  parameter int DIV_W    = 16
);
  localparam int IW = $clog2(DEPTH + 1);

  logic [CHANNELS-1:0]                     button;
  logic [2*CHANNELS-1:0]                   mode;
  logic [CHANNELS-1:0]                     sel;
  logic [DIV_W-1:0]                        period;
  logic                                    pal_we;
  logic [IW-1:0]                           pal_addr;
  logic [light_pkg::COLOUR_W-1:0]          pal_data;
  logic [IW*CHANNELS-1:0]                  index;
  logic [light_pkg::COLOUR_W*CHANNELS-1:0] light;

  modport master (
    output button, mode, sel, period, pal_we, pal_addr, pal_data,
    input  index, light
  );

  modport slave (
    input  button, mode, sel, period, pal_we, pal_addr, pal_data,
    output index, light
  );

endinterface

// File: rtl/light_sequencer_channel.sv
// One light channel: colour-index FSM, button history and auto-step prescaler.
module light_channel
  import light_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int DIV_W = 16,
  parameter int IW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] period,
  output logic [IW-1:0]    index
);

  localparam logic [0:0] ST_OFF = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;

  logic [0:0]       state;
  logic             btn_prev;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] limit;
  logic             auto_hit;
  logic             step;
  mode_e            chan_mode;

  assign chan_mode = mode_e'(mode);

  // A period of 0 behaves as 1; >= lets a shrunken period fire straight away.
  always_comb begin
    limit    = (period == '0) ? '0 : period - DIV_W'(1);
    auto_hit = (chan_mode == MODE_AUTO) && (presc >= limit);
    step     = 1'b0;
    case (chan_mode)
      MODE_LEVEL: step = button;
      MODE_EDGE:  step = button & ~btn_prev;
      MODE_AUTO:  step = auto_hit;
      default:    step = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_OFF;
      index    <= '0;
      btn_prev <= 1'b0;
      presc    <= '0;
    end else begin
      btn_prev <= button;
      if (chan_mode != MODE_AUTO || auto_hit) presc <= '0;
      else                                    presc <= presc + DIV_W'(1);

      if (state == ST_OFF) begin
        state <= ST_RUN;
        index <= IW'(1);
      end else if (step) begin
        index <= (index == IW'(DEPTH)) ? IW'(1) : index + IW'(1);
      end
    end
  end

endmodule

// File: rtl/light_sequencer.sv
// Top level: shared writable palette plus per-channel registered colour mux.
module light_sequencer
  import light_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 6,
  parameter int DIV_W    = 16
) (
  input logic           clk,
  input logic           rst,
  light_sequencer_if.slave bus
);

  localparam int IW = $clog2(DEPTH + 1);

  logic [COLOUR_W-1:0] palette    [1:DEPTH];
  logic [IW-1:0]       chan_index [CHANNELS];
  logic [COLOUR_W-1:0] light_q    [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    light_channel #(
      .DEPTH (DEPTH),
      .DIV_W (DIV_W),
      .IW    (IW)
    ) u_channel (
      .clk    (clk),
      .rst    (rst),
      .button (bus.button[c]),
      .mode   (bus.mode[2*c +: 2]),
      .period (bus.period),
      .index  (chan_index[c])
    );

    assign bus.index[c*IW +: IW]             = chan_index[c];
    assign bus.light[c*COLOUR_W +: COLOUR_W] = light_q[c];
  end

  // Writes outside 1..DEPTH are dropped; readers see new data from the next edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int e = 1; e <= DEPTH; e++) palette[e] <= default_colour(e);
    end else if (bus.pal_we && bus.pal_addr != '0 && bus.pal_addr <= IW'(DEPTH)) begin
      palette[bus.pal_addr] <= bus.pal_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (!rst)                     light_q[c] <= BLACK;
      else if (!bus.sel[c])         light_q[c] <= WHITE;
      else if (chan_index[c] == '0) light_q[c] <= BLACK;
      else                          light_q[c] <= palette[chan_index[c]];
    end
  end

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: vector table, directed corner cases and random run against a model.
module tb_light_sequencer;

  localparam int CH    = 4;
  localparam int DEPTH = 6;
  localparam int DIV_W = 16;
  localparam int IW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  light_sequencer_if #(.CHANNELS(CH), .DEPTH(DEPTH), .DIV_W(DIV_W)) bus ();

  light_sequencer #(.CHANNELS(CH), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          m_idx   [CH];
  bit          m_prev  [CH];
  int          m_cnt   [CH];
  logic [23:0] m_light [CH];
  logic [23:0] m_pal   [1:DEPTH];

  typedef struct {
    bit          rst;
    bit [3:0]    button;
    bit [7:0]    mode;
    bit [3:0]    sel;
    int          exp_idx0;
    logic [23:0] exp_light0;
  } vec_t;

  function automatic logic [23:0] ref_default(input int e);
    logic [23:0] table6 [6];
    table6 = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF};
    return (e >= 1 && e <= 6) ? table6[e-1] : 24'h808080;
  endfunction

  // Predicts state after the coming edge from the inputs currently applied.
  task automatic model_step();
    logic [23:0] nl [CH];
    int  p;
    int  m;
    bit  step;
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        m_idx[c] = 0; m_prev[c] = 0; m_cnt[c] = 0; m_light[c] = 24'h0;
      end
      for (int e = 1; e <= DEPTH; e++) m_pal[e] = ref_default(e);
    end else begin
      for (int c = 0; c < CH; c++)
        nl[c] = !bus.sel[c] ? 24'hFFFFFF : (m_idx[c] == 0 ? 24'h0 : m_pal[m_idx[c]]);
      p = (bus.period == 0) ? 1 : int'(bus.period);
      for (int c = 0; c < CH; c++) begin
        m = int'(bus.mode[2*c +: 2]);
        step = 0;
        if (m == 2) begin
          if (m_cnt[c] + 1 >= p) begin step = 1; m_cnt[c] = 0; end
          else m_cnt[c] = m_cnt[c] + 1;
        end else m_cnt[c] = 0;
        if (m == 0) step = bus.button[c];
        if (m == 1) step = bus.button[c] && !m_prev[c];
        if (m_idx[c] == 0) m_idx[c] = 1;
        else if (step) m_idx[c] = m_idx[c] % DEPTH + 1;
        m_prev[c]  = bus.button[c];
        m_light[c] = nl[c];
      end
      if (bus.pal_we && bus.pal_addr >= 1 && int'(bus.pal_addr) <= DEPTH)
        m_pal[bus.pal_addr] = bus.pal_data;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] dut_idx(input int c);
    return 32'(bus.index[c*IW +: IW]);
  endfunction

  function automatic logic [31:0] dut_light(input int c);
    return 32'(bus.light[c*24 +: 24]);
  endfunction

  // One clock: model predicts, edge happens, every channel is compared.
  task automatic apply_stimulus();
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      check_output($sformatf("model_idx_ch%0d", c), dut_idx(c), 32'(m_idx[c]));
      check_output($sformatf("model_light_ch%0d", c), dut_light(c), 32'(m_light[c]));
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus();
  endtask

  vec_t vecs [$];

  initial begin
    rst = 1'b0;
    bus.button = '0; bus.mode = '0; bus.sel = '1; bus.period = 16'd3;
    bus.pal_we = 1'b0; bus.pal_addr = '0; bus.pal_data = '0;
    #1;

    // Reset, release, then ch0 level-step held for eight cycles.
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'hF, 0, 24'h000000});
    vecs.push_back('{1'b1, 4'h0, 8'h00, 4'hF, 1, 24'h000000});
    vecs.push_back('{1'b1, 4'h0, 8'h00, 4'hF, 1, 24'hFF0000});
    vecs.push_back('{1'b1, 4'h1, 8'h00, 4'hF, 2, 24'hFF0000});
    vecs.push_back('{1'b1, 4'h1, 8'h00, 4'hF, 3, 24'h00FF00});
    vecs.push_back('{1'b1, 4'h1, 8'h00, 4'hF, 4, 24'h0000FF});
    vecs.push_back('{1'b1, 4'h1, 8'h00, 4'hF, 5, 24'hFFFF00});
    vecs.push_back('{1'b1, 4'h1, 8'h00, 4'hF, 6, 24'h00FFFF});
    vecs.push_back('{1'b1, 4'h1, 8'h00, 4'hF, 1, 24'hFF00FF});
    vecs.push_back('{1'b1, 4'h1, 8'h00, 4'hF, 2, 24'hFF0000});
    vecs.push_back('{1'b1, 4'h1, 8'h00, 4'hF, 3, 24'h00FF00});
    vecs.push_back('{1'b1, 4'h0, 8'h00, 4'hF, 3, 24'h0000FF});
    foreach (vecs[i]) begin
      rst = vecs[i].rst; bus.button = vecs[i].button;
      bus.mode = vecs[i].mode; bus.sel = vecs[i].sel;
      apply_stimulus();
      check_output($sformatf("vec%0d_idx0", i), dut_idx(0), 32'(vecs[i].exp_idx0));
      check_output($sformatf("vec%0d_light0", i), dut_light(0), 32'(vecs[i].exp_light0));
    end

    // Edge-step on ch1: two presses of five cycles give exactly two steps.
    bus.mode = 8'b00_00_01_00;
    for (int r = 0; r < 2; r++) begin
      bus.button = 4'b0010; run_cycles(5);
      check_output($sformatf("edge_press%0d_idx1", r), dut_idx(1), 32'(2 + r));
      bus.button = 4'b0000; run_cycles(2);
    end
    check_output("edge_final_idx1", dut_idx(1), 32'd3);

    // Auto-step on ch2 with period 3, then period drops to 1 at count 2.
    bus.mode = 8'b00_10_00_00; bus.period = 16'd3;
    run_cycles(2); check_output("auto_e2_idx2", dut_idx(2), 32'd1);
    run_cycles(1); check_output("auto_e3_idx2", dut_idx(2), 32'd2);
    run_cycles(3); check_output("auto_e6_idx2", dut_idx(2), 32'd3);
    run_cycles(2); check_output("auto_e8_idx2", dut_idx(2), 32'd3);
    bus.period = 16'd1;
    run_cycles(1); check_output("auto_shrink_idx2", dut_idx(2), 32'd4);
    run_cycles(1); check_output("auto_p1_idx2", dut_idx(2), 32'd5);
    bus.mode = 8'h00; bus.period = 16'd0;
    run_cycles(1); check_output("period0_hold_idx2", dut_idx(2), 32'd5);

    // Palette write while ch3 sits at index 2.
    bus.button = 4'b1000; run_cycles(1);
    check_output("pal_pre_idx3", dut_idx(3), 32'd2);
    bus.button = 4'b0000; run_cycles(1);
    check_output("pal_pre_light3", dut_light(3), 32'h00FF00);
    bus.pal_we = 1'b1; bus.pal_addr = 3'd2; bus.pal_data = 24'h123456; run_cycles(1);
    check_output("pal_write_cycle_light3", dut_light(3), 32'h00FF00);
    bus.pal_we = 1'b0; run_cycles(1);
    check_output("pal_after_light3", dut_light(3), 32'h123456);
    bus.pal_we = 1'b1; bus.pal_addr = 3'd0; bus.pal_data = 24'hABCDEF; run_cycles(1);
    bus.pal_addr = 3'd7; run_cycles(1);
    bus.pal_we = 1'b0; run_cycles(1);
    check_output("pal_addr0_ignored_light3", dut_light(3), 32'h123456);

    // White override on ch0 while it keeps stepping.
    bus.button = 4'b0001; bus.sel = 4'b1110; run_cycles(1);
    check_output("white_light0", dut_light(0), 32'hFFFFFF);
    check_output("white_idx0", dut_idx(0), 32'd4);
    run_cycles(1);
    check_output("white_step_idx0", dut_idx(0), 32'd5);
    bus.button = 4'b0000; bus.sel = 4'hF;

    // Reset mid-run with a write in the same cycle; palette returns to defaults.
    rst = 1'b0; bus.button = 4'hF; bus.pal_we = 1'b1; bus.pal_addr = 3'd2; bus.pal_data = 24'h111111;
    run_cycles(1);
    for (int c = 0; c < CH; c++) begin
      check_output($sformatf("rst_idx_ch%0d", c), dut_idx(c), 32'd0);
      check_output($sformatf("rst_light_ch%0d", c), dut_light(c), 32'd0);
    end
    rst = 1'b1; bus.button = 4'h0; bus.pal_we = 1'b0; run_cycles(1);
    check_output("rel_idx3", dut_idx(3), 32'd1);
    check_output("rel_light3", dut_light(3), 32'h000000);
    bus.button = 4'b1000; run_cycles(1);
    check_output("rel_step_light3", dut_light(3), 32'hFF0000);
    bus.button = 4'b0000; run_cycles(1);
    check_output("rel_default2_light3", dut_light(3), 32'h00FF00);

    // Random run against the model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      bus.button = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) bus.mode = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) bus.sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.period = 16'($urandom_range(0, 5));
      bus.pal_we   = ($urandom_range(0, 5) == 0);
      bus.pal_addr = 3'($urandom_range(0, 7));
      bus.pal_data = 24'($urandom);
      apply_stimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
# light_sequencer

Multi-channel successor to the single-channel lights selector. Each of CHANNELS channels steps a colour index through a shared, run-time-writable palette under its own mode: level-step, edge-step, auto-step or freeze. A per-channel white override muxes in WHITE. The block sits between the board buttons/switches and the RGB LED drivers, with one registered 24-bit colour per channel.

## Interface
- CHANNELS, 4: number of independent light channels.
- DEPTH, 6: palette entries, indices 1..DEPTH. Index 0 is the reset/off state. IW = $clog2(DEPTH+1).
- DIV_W, 16: width of the auto-step period.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-low.
- button  in  CHANNELS  per-channel step request.
- mode  in  2*CHANNELS  per-channel mode: 00 level-step, 01 edge-step, 10 auto-step, 11 freeze.
- sel  in  CHANNELS  1 = palette colour, 0 = WHITE.
- period  in  DIV_W  auto-step interval in cycles, shared. 0 is treated as 1.
- pal_we  in  1  palette write strobe.
- pal_addr  in  IW  palette write address. 0 or >DEPTH: write ignored.
- pal_data  in  24  palette write data.
- index  out  IW*CHANNELS  current per-channel index.
- light  out  24*CHANNELS  registered per-channel colour.

## Operation
- Reset (rst=0 at an edge) sets:
  - index = 0, light = 0, prescalers = 0, button history = 0.
  - Palette reloads defaults: 1 FF0000, 2 00FF00, 3 0000FF, 4 FFFF00, 5 00FFFF, 6 FF00FF; entries >6 = 808080.
- Index FSM per channel:
  - OFF (index 0): the first edge with rst=1 forces index to 1, regardless of mode or button.
  - RUN (1..DEPTH): a step sets index+1; DEPTH wraps to 1. Index never returns to 0 except via reset.
- Step condition per mode:
  - 00: button=1 at the edge; holding it steps every cycle.
  - 01: button=1 and previous sampled button=0.
  - 10: prescaler reaches max(period,1)-1, then clears; button ignored.
  - 11: no step.
- Button history is sampled every cycle in all modes, OFF included.
- Prescaler:
  - Counts only in mode 10.
  - Cleared on any cycle the channel's mode is not 10, so entering auto starts a fresh interval.
  - If period shrinks below the current count, the channel steps on the next edge and clears.
- Light mux (registered):
  - light = WHITE when sel=0.
  - Otherwise 000000 when index=0, else palette[index].
- Palette write: pal_we at an edge updates the entry. A same-cycle read of that entry returns old data; the new data is visible from the next edge.
- Channels are fully independent; all share the palette and period.

## Timing
- Step request sampled at edge N: index changes at N, light reflects it at N+1 (one-cycle colour latency).
- sel change sampled at N: light updates at N.
- Palette write at N: affected channels show the new colour at N+1.
- Out of reset: light = 0 through the first run edge. index=1 after that edge; light = palette[1] (or WHITE) one edge later.
- Reset mid-run or mid-write wins over all other activity; a write in the reset cycle is discarded.
- Auto mode with period=P: one step every P cycles exactly; P=1 steps every cycle.

## Structure
- Package light_pkg holds:
  - COLOUR_W=24, WHITE=24'hFFFFFF, BLACK=24'h000000.
  - The mode encoding enum: MODE_LEVEL, MODE_EDGE, MODE_AUTO, MODE_FREEZE.
  - A default-palette function indexed by entry number.
- Sub-module light_channel contains index FSM, button history and prescaler; it is instantiated CHANNELS times via generate.
- The top level holds the palette register array and the per-channel registered light mux.

## Test plan
- Reset and release, all channels mode 00, button=0, sel=1: index 0 → 1 after the first edge, light = FF0000 one edge later, then held.
- Ch0 mode 00, button held 8 cycles: index 1,2,3,4,5,6,1,2. Light follows one cycle behind: FF0000, 00FF00, …, FF00FF, FF0000.
- Ch1 mode 01, button high for 5 cycles then low 2, twice: exactly two steps (1→2→3).
- Ch2 mode 10, period=3: a step every 3 cycles. Change period to 1 mid-interval with count=2: step on the next edge, then every cycle.
- Write pal_addr=2, pal_data=123456 while ch3 sits at index 2: light = 00FF00 in the write cycle, 123456 from the next edge. pal_addr=0 write leaves all entries unchanged.
- sel=0 on ch0 mid-run: light = FFFFFF next edge while index keeps stepping. Assert rst=0 mid-run: all light=0, index=0, palette restored to defaults.
